funct_generator_wave: RTL

//  Phase-accumulator waveform source for the function generator. Produces four signed

---
 rtl/funct_generator_pkg.sv | 22 ++
 rtl/funct_generator_shaper.sv | 35 +++
 rtl/funct_generator_wave.sv | 112 +++++++++++
 3 files changed

// File: rtl/funct_generator_pkg.sv
// Shared types and constants for the function generator.
// Wave index enum matches the output mux select encoding.
package funct_generator_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_RAMP   = 2'd3
    } wave_e;

    localparam int unsigned WAVE_NUM = 4;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_PHASE_W = 32;
    localparam int unsigned DEF_AMP_W   = 16;

    // Reset duty is half scale; unity gain is the amp MSB alone.
    localparam logic [DEF_PHASE_W-1:0] DUTY_RST  = 32'h8000_0000;
    localparam logic [DEF_AMP_W-1:0]   AMP_UNITY = 16'h8000;

endpackage

// File: rtl/funct_generator_shaper.sv
// Combinational phase -> {square, saw, triangle, ramp} shaping.
// Ports: ph_i phase, duty_i square threshold, wave_o indexed by wave_e.
module funct_generator_shaper
    import funct_generator_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PHASE_WIDTH = 32
) (
    input  logic [PHASE_WIDTH-1:0]              ph_i,
    input  logic [PHASE_WIDTH-1:0]              duty_i,
    output logic [WAVE_NUM-1:0][DATA_WIDTH-1:0] wave_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] ph;
    logic [W-1:0] fold;
    logic [W-1:0] saw;

    assign ph   = ph_i[PHASE_WIDTH-1 -: W];
    // Doubled phase; mirrored in the upper half to form the triangle.
    assign fold = {ph[W-2:0], 1'b0};
    // Flipping the MSB maps unsigned phase to a signed ramp.
    assign saw  = ph ^ MSB;

    always_comb begin
        wave_o              = '0;
        wave_o[WAVE_SAW]    = saw;
        wave_o[WAVE_RAMP]   = ~saw;
        wave_o[WAVE_TRI]    = (ph[W-1] ? ~fold : fold) ^ MSB;
        wave_o[WAVE_SQUARE] = (ph_i < duty_i) ? ~MSB : MSB;
    end

endmodule

// File: rtl/funct_generator_wave.sv
// Phase-accumulator source of four amplitude-scaled signed waveforms.
// Ports: enh step, cfg_we_i/freq_i/duty_i/amp_i config, sync_i phase reset,
//        data_0..3_o square/saw/tri/ramp, valid_o new sample, wrap_o overflow.
module funct_generator_wave
    import funct_generator_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PHASE_WIDTH = 32,
    parameter int AMP_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enh,
    input  logic                   cfg_we_i,
    input  logic [PHASE_WIDTH-1:0] freq_i,
    input  logic [PHASE_WIDTH-1:0] duty_i,
    input  logic [AMP_WIDTH-1:0]   amp_i,
    input  logic                   sync_i,
    output logic [DATA_WIDTH-1:0]  data_0_o,
    output logic [DATA_WIDTH-1:0]  data_1_o,
    output logic [DATA_WIDTH-1:0]  data_2_o,
    output logic [DATA_WIDTH-1:0]  data_3_o,
    output logic                   valid_o,
    output logic                   wrap_o
);

    localparam int W = DATA_WIDTH;
    localparam int P = PHASE_WIDTH;
    localparam int A = AMP_WIDTH;

    localparam logic [P-1:0] DUTY_INIT = {1'b1, {(P-1){1'b0}}};
    localparam logic [A-1:0] AMP_ONE   = {1'b1, {(A-1){1'b0}}};

    typedef logic [WAVE_NUM-1:0][W-1:0] waves_t;

    logic [P-1:0]   freq_q, duty_q, phase_q, ph_s0_q;
    logic [A-1:0]   amp_q, amp_d;
    logic [P:0]     sum_d;
    logic           v0_q, v1_q, valid_q, wrap_q;
    waves_t         shp_d, shp_q, scl_d, data_q;
    logic signed [W+A:0] amp_ext;

    assign sum_d   = {1'b0, phase_q} + {1'b0, freq_q};
    assign amp_d   = (amp_i > AMP_ONE) ? AMP_ONE : amp_i;
    assign amp_ext = {{(W+1){1'b0}}, amp_q};

    funct_generator_shaper #(
        .DATA_WIDTH (W),
        .PHASE_WIDTH(P)
    ) u_shaper (
        .ph_i  (ph_s0_q),
        .duty_i(duty_q),
        .wave_o(shp_d)
    );

    // Gain <= 1 keeps the floored product within W bits.
    always_comb begin
        scl_d = '0;
        for (int i = 0; i < WAVE_NUM; i++) begin
            scl_d[i] = W'(($signed({{(A+1){shp_q[i][W-1]}}, shp_q[i]})
                           * amp_ext) >>> (A-1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q  <= '0;
            duty_q  <= DUTY_INIT;
            amp_q   <= AMP_ONE;
            phase_q <= '0;
            ph_s0_q <= '0;
            shp_q   <= '0;
            data_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                freq_q <= freq_i;
                duty_q <= duty_i;
                amp_q  <= amp_d;
            end
            if (sync_i) begin
                phase_q <= '0;
            end else if (enh) begin
                phase_q <= sum_d[P-1:0];
            end
            wrap_q <= enh & ~sync_i & sum_d[P];
            if (enh) begin
                ph_s0_q <= phase_q;
            end
            v0_q <= enh;
            if (v0_q) begin
                shp_q <= shp_d;
            end
            v1_q <= v0_q;
            if (v1_q) begin
                data_q <= scl_d;
            end
            valid_q <= v1_q;
        end
    end

    assign data_0_o = data_q[WAVE_SQUARE];
    assign data_1_o = data_q[WAVE_SAW];
    assign data_2_o = data_q[WAVE_TRI];
    assign data_3_o = data_q[WAVE_RAMP];
    assign valid_o  = valid_q;
    assign wrap_o   = wrap_q;

endmodule
